fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and issues single-outstanding requests on an SRAM-like instruction port (addr handshake, then data handshake).
- Delivers instrD/pcD/pcPlus4D to decode, and obeys stallF/stallD from the hazard unit.
- Applies taken-branch redirects from decode with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'hBFC00000, PC value after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallF  in  1  hazard: hold PC.
- stallD  in  1  hazard: hold IF/ID register.
- pcSrcD  in  1  taken branch/jump resolved in decode this cycle.
- pcBranchD  in  ADDR_W  redirect target.
- instReq  out  1  instruction request valid.
- instAddr  out  ADDR_W  request address.
- instAddrOk  in  1  request accepted this cycle.
- instDataOk  in  1  read data valid this cycle.
- instRdata  in  32  read data.
- instrD  out  32  decode-stage instruction.
- pcD  out  ADDR_W  decode-stage PC.
- pcPlus4D  out  ADDR_W  pcD+4.
- validD  out  1  instrD holds a real instruction.
- fetchStallF  out  1  fetch cannot supply an instruction this cycle.

Behaviour:
- Reset (async, immediate):
  - pcF=RESET_PC; FSM=IDLE; instReq=0 during reset.
  - instrD=32'h0, pcD=0, pcPlus4D=0, validD=0.
  - pendRedir=0, holdReg=0.
- FSM states:
  - IDLE: instReq=1, instAddr=pcF. instAddrOk -> WAIT, and reqPc latches pcF.
  - WAIT: instReq=0. On instDataOk:
    - stallD=0: deliver instRdata -> IDLE.
    - stallD=1: latch instRdata into holdReg -> HOLD.
  - HOLD: instReq=0. When stallD=0: deliver holdReg -> IDLE.
- "Deliver" (same edge):
  - instrD=data, pcD=reqPc, pcPlus4D=reqPc+4, validD=1.
  - pcF advances, and only when stallF=0: pendRedir ? redirTgt : reqPc+4. pendRedir clears.
- Bubble: stallD=0 and no delivery this cycle -> instrD=32'h0 (sll nop), validD=0, pcD/pcPlus4D hold.
- stallD=1: IF/ID register holds all fields unchanged.
- fetchStallF = !(state==HOLD || (state==WAIT && instDataOk)). Combinational.
- Latency:
  - Request issued in the IDLE cycle.
  - With zero-wait memory (addrOk same cycle, dataOk next cycle), one instruction is delivered every 2 cycles.
- Redirect, sampled only when pcSrcD=1 and stallD=0:
  - The instruction currently in flight is the delay slot and is always delivered.
  - Delivery on the same edge: pcF=pcBranchD directly.
  - Otherwise: set pendRedir=1, redirTgt={pcBranchD[ADDR_W-1:2],2'b00}; applied at the next delivery.
  - A second redirect while pendRedir=1 overwrites redirTgt (legal only after the delay slot has issued).
- pcF[1:0] is always 2'b00. Branch target low bits are forced to 0.
- Simultaneous events:
  - instAddrOk in IDLE while stallF=1 is still accepted, because pcF does not change until delivery.
  - Delivery with stallF=1 and stallD=0 is illegal. An assertion flags it (the hazard unit drives both equal).
- Reset mid-transaction:
  - The instruction memory shares rst, so no stale instDataOk can arrive afterwards.
  - Any instDataOk seen in IDLE is ignored (assertion).
- PC arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perfFetchCnt[31:0] (+1 per delivery) and perfBubbleCnt[31:0] (+1 per bubble cycle).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mycpu_pkg:
  - fetch_state_t enum (IDLE, WAIT, HOLD).
  - NOP_INSTR=32'h0.
  - RESET_PC_DEF=32'hBFC00000.
- Sub-module if_id_reg: loads {instr,pc,pc+4,valid} with stall-hold and bubble-insert inputs.
  - The FSM, PC and redirect logic stay in fetch_stage.

Test Plan:
- Reset release, zero-wait memory returning addr*2 -> instAddr 0xBFC00000, 0xBFC00004, ... every 2 cycles; validD=1 with pcD matching.
- stallD=1 held 3 cycles while data returns in WAIT -> HOLD entered; instrD unchanged; on release, instrD=held word and pcD=0xBFC00008.
- pcSrcD=1, pcBranchD=0xBFC00100 at branch 0xBFC00010, delay slot 0xBFC00014 still in WAIT -> 0xBFC00014 delivered; next instAddr=0xBFC00100.
- Same redirect with delay slot delivered on the same edge -> next instAddr=0xBFC00100 with no extra bubble.
- instDataOk delayed 4 cycles, stallD=0 -> 4 bubbles (validD=0, instrD=0, fetchStallF=1); perfBubbleCnt=4 with FETCH_PERF_EN.
- rst asserted while in WAIT -> instReq=0 and validD=0 immediately; after release instAddr=0xBFC00000.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the MIPS core front end.
package mycpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: stall holds every field, load captures a new
// instruction, bubble inserts a nop while keeping the PC fields.
module if_id_reg
  import mycpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              load,
  input  logic              bubble,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_d    <= instr;
        pc_d       <= pc;
        pc_plus4_d <= pc_plus4;
        valid_d    <= 1'b1;
      end else if (bubble) begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register: single-outstanding instruction port,
// delay-slot redirects. Define FETCH_PERF_EN to add delivery/bubble counters.
module fetch_stage
  import mycpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              pcSrcD,
  input  logic [ADDR_W-1:0] pcBranchD,
  output logic              instReq,
  output logic [ADDR_W-1:0] instAddr,
  input  logic              instAddrOk,
  input  logic              instDataOk,
  input  logic [31:0]       instRdata,
  output logic [31:0]       instrD,
  output logic [ADDR_W-1:0] pcD,
  output logic [ADDR_W-1:0] pcPlus4D,
  output logic              validD,
  output logic              fetchStallF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perfFetchCnt,
  output logic [31:0]       perfBubbleCnt
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;
  logic [31:0]       hold_reg;
  logic              pend_redir_reg;
  logic [ADDR_W-1:0] redir_tgt_reg;

  logic              data_ok_wait;
  logic              deliver;
  logic              bubble;
  logic              redir;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] req_pc_plus4;
  logic [31:0]       deliver_data;

  assign data_ok_wait = (state_reg == WAIT) && instDataOk;
  assign deliver      = !stallD && (data_ok_wait || (state_reg == HOLD));
  assign bubble       = !stallD && !deliver;
  assign redir        = pcSrcD && !stallD;
  assign branch_tgt   = pcBranchD & ~ADDR_W'(3);
  assign req_pc_plus4 = req_pc_reg + ADDR_W'(4);
  assign deliver_data = (state_reg == HOLD) ? hold_reg : instRdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (instAddrOk) state_next = WAIT;
      WAIT: if (instDataOk) state_next = stallD ? HOLD : IDLE;
      HOLD: if (!stallD)    state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // The request is masked during reset because the state already reads IDLE.
  always_comb begin
    instReq     = (state_reg == IDLE) && !rst;
    instAddr    = pc_reg;
    fetchStallF = !((state_reg == HOLD) || data_ok_wait);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      req_pc_reg     <= '0;
      hold_reg       <= NOP_INSTR;
      pend_redir_reg <= 1'b0;
      redir_tgt_reg  <= '0;
    end else begin
      if ((state_reg == IDLE) && instAddrOk) begin
        req_pc_reg <= pc_reg;
      end
      if (data_ok_wait && stallD) begin
        hold_reg <= instRdata;
      end
      // The in-flight instruction is the delay slot; the redirect lands after it.
      if (deliver) begin
        pend_redir_reg <= 1'b0;
        if (!stallF) begin
          if (redir) begin
            pc_reg <= branch_tgt;
          end else if (pend_redir_reg) begin
            pc_reg <= redir_tgt_reg;
          end else begin
            pc_reg <= req_pc_plus4;
          end
        end
      end else if (redir) begin
        pend_redir_reg <= 1'b1;
        redir_tgt_reg  <= branch_tgt;
      end
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (stallD),
    .load      (deliver),
    .bubble    (bubble),
    .instr     (deliver_data),
    .pc        (req_pc_reg),
    .pc_plus4  (req_pc_plus4),
    .instr_d   (instrD),
    .pc_d      (pcD),
    .pc_plus4_d(pcPlus4D),
    .valid_d   (validD)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_reg;
  logic [31:0] perf_bubble_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_reg  <= '0;
      perf_bubble_reg <= '0;
    end else begin
      if (deliver) perf_fetch_reg  <= perf_fetch_reg + 32'd1;
      if (bubble)  perf_bubble_reg <= perf_bubble_reg + 32'd1;
    end
  end

  assign perfFetchCnt  = perf_fetch_reg;
  assign perfBubbleCnt = perf_bubble_reg;
`endif

  // Hazard unit drives stallF and stallD together, so delivery never sees stallF.
  assert property (@(posedge clk) disable iff (rst) !(deliver && stallF));
  // Memory shares rst, so read data can only arrive for an accepted request.
  assert property (@(posedge clk) disable iff (rst) !((state_reg == IDLE) && instDataOk));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level memory and program-order
// model predict the request stream and the IF/ID contents every cycle.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, pcSrcD;
  logic [31:0] pcBranchD;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instAddrOk, instDataOk;
  logic [31:0] instRdata;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic        validD, fetchStallF;
`ifdef FETCH_PERF_EN
  logic [31:0] perfFetchCnt, perfBubbleCnt;
`endif

  fetch_stage #(
    .ADDR_W  (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcSrcD     (pcSrcD),
    .pcBranchD  (pcBranchD),
    .instReq    (instReq),
    .instAddr   (instAddr),
    .instAddrOk (instAddrOk),
    .instDataOk (instDataOk),
    .instRdata  (instRdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .pcPlus4D   (pcPlus4D),
    .validD     (validD),
    .fetchStallF(fetchStallF)
`ifdef FETCH_PERF_EN
    ,
    .perfFetchCnt (perfFetchCnt),
    .perfBubbleCnt(perfBubbleCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory / program-order model
  bit          mem_busy, held, redir_armed, dec_valid;
  logic [31:0] mem_addr, held_addr, exp_next, redir_tgt;
  logic [31:0] dec_pc, dec_pc4, dec_instr;
  int          mem_lat;
  int          n_deliver, n_bubble;
  int          p_addr, p_stall, p_br, max_lat;

  task automatic reset_model();
    mem_busy    = 0;
    held        = 0;
    redir_armed = 0;
    dec_valid   = 0;
    mem_addr    = '0;
    held_addr   = '0;
    exp_next    = RST_PC;
    redir_tgt   = '0;
    dec_pc      = '0;
    dec_pc4     = '0;
    dec_instr   = '0;
    mem_lat     = 0;
    n_deliver   = 0;
    n_bubble    = 0;
  endtask

  task automatic check_ifid();
    check_val("validD", 32'(validD), 32'(dec_valid));
    check_val("instrD", instrD, dec_instr);
    check_val("pcD", pcD, dec_pc);
    check_val("pcPlus4D", pcPlus4D, dec_pc4);
  endtask

  task automatic run_cycle();
    bit          dok, dlv, idle;
    logic [31:0] dpc;
    idle   = !(mem_busy || held);
    stallD = ($urandom_range(99) < p_stall);
    stallF = stallD;
    dok    = mem_busy && (mem_lat == 0);
    instDataOk = dok;
    instRdata  = dok ? mem_addr * 2 : $urandom();
    instAddrOk = idle && ($urandom_range(99) < p_addr);
    pcBranchD  = $urandom();
    pcSrcD     = 1'b0;
    if (!stallD && dec_valid && !redir_armed && ($urandom_range(99) < p_br)) pcSrcD = 1'b1;
    else if (stallD && ($urandom_range(99) < 10)) pcSrcD = 1'b1;
    #1;
    check_val("instReq", 32'(instReq), 32'(idle));
    if (idle) check_val("instAddr", instAddr, exp_next);
    check_val("fetchStallF", 32'(fetchStallF), 32'(!(held || dok)));
    dlv = !stallD && (held || dok);
    dpc = held ? held_addr : mem_addr;

    @(posedge clk);
    #1;
    if (pcSrcD && !stallD) begin
      redir_armed = 1;
      redir_tgt   = pcBranchD & 32'hFFFF_FFFC;
    end
    if (dok) begin
      mem_busy = 0;
      if (stallD) begin
        held      = 1;
        held_addr = mem_addr;
      end
    end else if (mem_busy) begin
      mem_lat--;
    end
    if (dlv) begin
      held      = 0;
      dec_valid = 1;
      dec_pc    = dpc;
      dec_pc4   = dpc + 32'd4;
      dec_instr = dpc * 2;
      exp_next  = redir_armed ? redir_tgt : dpc + 32'd4;
      redir_armed = 0;
      n_deliver++;
      $display("deliver pc=%h instr=%h next_fetch=%h", dpc, dpc * 2, exp_next);
    end else if (!stallD) begin
      dec_valid = 0;
      dec_instr = 32'h0;
      n_bubble++;
    end
    if (instAddrOk) begin
      mem_busy = 1;
      mem_addr = exp_next;
      mem_lat  = int'($urandom_range(max_lat));
    end
    check_ifid();
  endtask

  task automatic reset_mid();
    rst        = 1'b1;
    instAddrOk = 1'b0;
    instDataOk = 1'b0;
    pcSrcD     = 1'b0;
    stallD     = 1'b0;
    stallF     = 1'b0;
    #1;
    check_val("rst_instReq", 32'(instReq), 32'h0);
    check_val("rst_validD", 32'(validD), 32'h0);
    check_val("rst_instrD", instrD, 32'h0);
    $display("reset asserted mid-transaction at %0t", $time);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    int resets_done;
    resets_done = 0;
    rst = 1'b1;
    stallF = 1'b0; stallD = 1'b0; pcSrcD = 1'b0; pcBranchD = '0;
    instAddrOk = 1'b0; instDataOk = 1'b0; instRdata = '0;
    reset_model();
    #1;
    check_val("reset_instReq", 32'(instReq), 32'h0);
    check_val("reset_fetchStallF", 32'(fetchStallF), 32'h1);
    check_ifid();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait memory, no hazards: one delivery every 2 cycles.
    p_addr = 100; max_lat = 0; p_stall = 0; p_br = 0;
    repeat (20) run_cycle();

    // Random latency, stalls and redirects.
    p_addr = 70; max_lat = 4; p_stall = 30; p_br = 15;
    for (int i = 0; i < 600; i++) begin
      run_cycle();
      if (mem_busy && !held && resets_done < 2 && i > 200 && $urandom_range(99) < 5) begin
        reset_mid();
        resets_done++;
      end
    end

    // Zero-wait with frequent branches to hit same-edge redirects.
    p_addr = 100; max_lat = 0; p_stall = 10; p_br = 40;
    repeat (200) run_cycle();

`ifdef FETCH_PERF_EN
    check_val("perfFetchCnt", perfFetchCnt, 32'(n_deliver));
    check_val("perfBubbleCnt", perfBubbleCnt, 32'(n_bubble));
`endif
    if (resets_done == 0) begin
      rst = 1'b1;
      #1;
      check_val("late_rst_instReq", 32'(instReq), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
